sequence_timing_unit: RTL and testbench

Generates the timing and decode inputs consumed by the control unit: the one-hot timing vector T, the one-hot opcode vector D, the indirect bit I and the register-reference bit field B. It owns the 3-bit sequence counter (SC), the 8-bit instruction register (IR) and the I flip-flop, plus a run/halt state machine and a retired-instruction counter. It is driven by the control unit's LDIR and CLRSC strobes and by the common bus.

---
 rtl/sequence_timing_unit_pkg.sv | 29 ++
 rtl/sequence_timing_unit_seq_counter.sv | 29 ++
 rtl/sequence_timing_unit.sv | 78 +++++++
 tb/tb_sequence_timing_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_timing_unit_pkg.sv
// Shared field positions, opcodes, run/halt state type and the 3->8 one-hot decoder.
// Used by the sequence timing unit and its sequence counter.
package sequence_timing_unit_pkg;

    localparam int SC_W    = 3;
    localparam int I_BIT   = 7;
    localparam int OP_MSB  = 6;
    localparam int OP_LSB  = 4;
    localparam int ADR_MSB = 3;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_LDA     = 3'd2;
    localparam logic [2:0] OP_STA     = 3'd3;
    localparam logic [2:0] OP_BUN     = 3'd4;
    localparam logic [2:0] OP_BSA     = 3'd5;
    localparam logic [2:0] OP_ISZ     = 3'd6;
    localparam logic [2:0] OP_REG_REF = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] v);
        onehot8 = 8'h01 << v;
    endfunction

endpackage

// File: rtl/sequence_timing_unit_seq_counter.sv
// Purpose: 3-bit sequence counter with increment, clear, hold and sticky wrap flag.
// Latency: count and flag update on the clock edge after inc/clr are sampled.
// Backpressure: none; holds its value whenever neither inc nor clr is asserted.
module seq_counter
    import sequence_timing_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    output logic [SC_W-1:0] sc,
    output logic            wrap
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sc   <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            // an explicit clear at the top count is a normal end of instruction, not a wrap
            sc <= '0;
        end else if (inc) begin
            sc <= sc + 1'b1;
            if (sc == '1)
                wrap <= 1'b1;
        end
    end

endmodule

// File: rtl/sequence_timing_unit.sv
// Purpose: timing (T), decode (D, B) and indirect (I) generation for the control unit, with run/halt FSM.
// Latency: T/I/running/sc_wrap/instr_count registered (1 cycle); D/B combinational from IR.
// Backpressure: none; ld_ir/clr_sc are ignored in IDLE, halt_req takes effect at the next clr_sc.
module sequence_timing_unit
    import sequence_timing_unit_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int AUTO_RUN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       bus,
    input  logic             ld_ir,
    input  logic             clr_sc,
    input  logic             start,
    input  logic             halt_req,
    output logic [7:0]       T,
    output logic [7:0]       D,
    output logic             I,
    output logic [7:0]       B,
    output logic             running,
    output logic             sc_wrap,
    output logic [CNT_W-1:0] instr_count
);

    state_t          state;
    logic [7:0]      ir;
    logic [SC_W-1:0] sc;
    logic            sc_inc;
    logic            sc_clr;

    assign running = (state == RUN);
    assign sc_inc  = running & ~clr_sc;
    assign sc_clr  = running & clr_sc;

    seq_counter u_seq_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (sc_inc),
        .clr  (sc_clr),
        .sc   (sc),
        .wrap (sc_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (AUTO_RUN != 0) ? RUN : IDLE;
            ir          <= '0;
            I           <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= RUN;
                end
                RUN: begin
                    if (ld_ir)
                        ir <= bus;
                    // I is captured from the IR loaded at T1, so it is stable from T3
                    if (sc == SC_W'(2))
                        I <= ir[I_BIT];
                    if (clr_sc) begin
                        instr_count <= instr_count + CNT_W'(1);
                        if (halt_req)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign T = running ? onehot8(sc) : 8'h00;
    assign D = onehot8(ir[OP_MSB:OP_LSB]);
    assign B = {4'b0000, ir[ADR_MSB:0]};

endmodule

// File: tb/tb_sequence_timing_unit.sv
// Directed bench: two instances (AUTO_RUN=1/CNT_W=4 and AUTO_RUN=0/CNT_W=16) against an abstract per-cycle model.
module tb_sequence_timing_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  bus;
    logic        ld_ir;
    logic        clr_sc;
    logic        start;
    logic        halt_req;

    logic [7:0]  t1, d1, b1, t0, d0, b0;
    logic        i1, run1, wrap1, i0, run0, wrap0;
    logic [3:0]  cnt1;
    logic [15:0] cnt0;

    int compared   = 0;
    int mismatched = 0;

    sequence_timing_unit #(.CNT_W(4), .AUTO_RUN(1)) u_auto (
        .clk(clk), .rst(rst), .bus(bus), .ld_ir(ld_ir), .clr_sc(clr_sc),
        .start(start), .halt_req(halt_req),
        .T(t1), .D(d1), .I(i1), .B(b1), .running(run1), .sc_wrap(wrap1),
        .instr_count(cnt1)
    );

    sequence_timing_unit #(.CNT_W(16), .AUTO_RUN(0)) u_idle (
        .clk(clk), .rst(rst), .bus(bus), .ld_ir(ld_ir), .clr_sc(clr_sc),
        .start(start), .halt_req(halt_req),
        .T(t0), .D(d0), .I(i0), .B(b0), .running(run0), .sc_wrap(wrap0),
        .instr_count(cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Abstract machine state: step count within the instruction, IR contents, flags, retired total.
    typedef struct {
        bit         run;
        int         sc;
        logic [7:0] ir;
        bit         ibit;
        bit         wrap;
        int         cnt;
    } mdl_t;

    mdl_t m1, m0;
    bit   mvalid = 1'b0;

    function automatic mdl_t step(mdl_t m, bit auto_run, int cnt_mod);
        mdl_t n = m;
        if (rst) begin
            n.run = auto_run; n.sc = 0; n.ir = 8'h00; n.ibit = 0; n.wrap = 0; n.cnt = 0;
            return n;
        end
        if (!m.run) begin
            if (start) n.run = 1;
            n.sc = 0;
        end else begin
            if (ld_ir) n.ir = bus;
            if (m.sc == 2) n.ibit = m.ir[7];
            if (clr_sc) begin
                n.sc  = 0;
                n.cnt = (m.cnt + 1) % cnt_mod;
                if (halt_req) n.run = 0;
            end else begin
                n.sc = (m.sc + 1) % 8;
                if (m.sc == 7) n.wrap = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 = step(m1, 1'b1, 16);
        m0 = step(m0, 1'b0, 65536);
        if (rst) mvalid = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_t(mdl_t m);
        logic [7:0] one = 8'h01;
        return m.run ? (one << m.sc) : 8'h00;
    endfunction

    function automatic logic [7:0] exp_d(mdl_t m);
        logic [7:0] one = 8'h01;
        return one << m.ir[6:4];
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            chk("auto.T",       32'(t1),    32'(exp_t(m1)));
            chk("auto.D",       32'(d1),    32'(exp_d(m1)));
            chk("auto.B",       32'(b1),    32'({4'h0, m1.ir[3:0]}));
            chk("auto.I",       32'(i1),    32'(m1.ibit));
            chk("auto.running", 32'(run1),  32'(m1.run));
            chk("auto.sc_wrap", 32'(wrap1), 32'(m1.wrap));
            chk("auto.count",   32'(cnt1),  32'(m1.cnt));
            chk("idle.T",       32'(t0),    32'(exp_t(m0)));
            chk("idle.D",       32'(d0),    32'(exp_d(m0)));
            chk("idle.B",       32'(b0),    32'({4'h0, m0.ir[3:0]}));
            chk("idle.I",       32'(i0),    32'(m0.ibit));
            chk("idle.running", 32'(run0),  32'(m0.run));
            chk("idle.sc_wrap", 32'(wrap0), 32'(m0.wrap));
            chk("idle.count",   32'(cnt0),  32'(m0.cnt));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; bus = 8'h00; ld_ir = 1'b0; clr_sc = 1'b0; start = 1'b0; halt_req = 1'b0;
        cyc(1);
        rst = 1'b0;
        chk("lit.rst_auto_T",   32'(t1),   32'h01);
        chk("lit.rst_idle_T",   32'(t0),   32'h00);
        chk("lit.rst_D",        32'(d1),   32'h01);
        chk("lit.rst_B",        32'(b1),   32'h00);
        chk("lit.rst_idle_run", 32'(run0), 32'h0);

        // free-running walk through all eight steps and the wrap
        cyc(7);
        chk("lit.walk_T80",  32'(t1),    32'h80);
        chk("lit.walk_nowr", 32'(wrap1), 32'h0);
        cyc(1);
        chk("lit.walk_T01",  32'(t1),    32'h01);
        chk("lit.walk_wrap", 32'(wrap1), 32'h1);

        // bus=13: memory-ref opcode 1, ends at T4
        cyc(1);
        bus = 8'h13; ld_ir = 1'b1;
        cyc(1);
        ld_ir = 1'b0;
        chk("lit.i13_D", 32'(d1), 32'h02);
        chk("lit.i13_B", 32'(b1), 32'h03);
        cyc(1);
        chk("lit.i13_I", 32'(i1), 32'h0);
        cyc(1);
        clr_sc = 1'b1;
        cyc(1);
        clr_sc = 1'b0;
        chk("lit.i13_T",   32'(t1),   32'h01);
        chk("lit.i13_cnt", 32'(cnt1), 32'h1);

        // bus=F4: register-reference with I set, ends at T3
        cyc(1);
        bus = 8'hF4; ld_ir = 1'b1;
        cyc(1);
        ld_ir = 1'b0;
        chk("lit.iF4_D", 32'(d1), 32'h80);
        chk("lit.iF4_B", 32'(b1), 32'h04);
        cyc(1);
        chk("lit.iF4_I", 32'(i1), 32'h1);
        clr_sc = 1'b1;
        cyc(1);
        clr_sc = 1'b0;
        chk("lit.iF4_T", 32'(t1), 32'h01);

        // start only affects the idle instance; then halt both at the next boundary
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("lit.start_idle_T", 32'(t0), 32'h01);
        chk("lit.start_auto_T", 32'(t1), 32'h02);
        halt_req = 1'b1;
        cyc(4);
        clr_sc = 1'b1;
        cyc(1);
        clr_sc = 1'b0; halt_req = 1'b0;
        chk("lit.halt_T",   32'(t1),   32'h00);
        chk("lit.halt_run", 32'(run1), 32'h0);
        bus = 8'h55; ld_ir = 1'b1;
        cyc(1);
        ld_ir = 1'b0;
        chk("lit.idle_ldir_D", 32'(d1), 32'h80);
        chk("lit.idle_ldir_B", 32'(b1), 32'h04);
        start = 1'b1; clr_sc = 1'b1;
        cyc(1);
        start = 1'b0; clr_sc = 1'b0;
        chk("lit.restart_T",   32'(t1),   32'h01);
        chk("lit.restart_run", 32'(run1), 32'h1);

        // clr_sc at step 7 on the instance whose wrap flag is still clear
        cyc(7);
        chk("lit.s7_T", 32'(t0), 32'h80);
        clr_sc = 1'b1;
        cyc(1);
        clr_sc = 1'b0;
        chk("lit.s7_T01",  32'(t0),    32'h01);
        chk("lit.s7_nowr", 32'(wrap0), 32'h0);

        // reset mid-instruction with start and halt_req pending
        cyc(3);
        rst = 1'b1; start = 1'b1; halt_req = 1'b1;
        cyc(1);
        rst = 1'b0; start = 1'b0; halt_req = 1'b0;
        chk("lit.mrst_T",    32'(t1),    32'h01);
        chk("lit.mrst_I",    32'(i1),    32'h0);
        chk("lit.mrst_wrap", 32'(wrap1), 32'h0);
        chk("lit.mrst_cnt",  32'(cnt1),  32'h0);
        chk("lit.mrst_D",    32'(d1),    32'h01);
        chk("lit.mrst_idle", 32'(run0),  32'h0);

        // 16 back-to-back single-cycle instructions wrap the 4-bit counter
        clr_sc = 1'b1;
        cyc(15);
        chk("lit.cnt_F", 32'(cnt1), 32'hF);
        cyc(1);
        clr_sc = 1'b0;
        chk("lit.cnt_0", 32'(cnt1), 32'h0);
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
